button_press_emulator: RTL

- Inverse of the lab2 8-to-3 priority button encoder: accepts an encoded button index and drives a synthetic active-low button bus.
- The bus is driven so the priority encoder reproduces the same index.
- Each press is held for a programmable number of cycles, then followed by a release gap.
- Sits between a stimulus source (UART/command decoder or testbench) and the `buttons` input of the encoder design.

---
 rtl/button_press_emulator_pkg.sv | 25 ++
 rtl/button_press_emulator_if.sv | 12 +
 rtl/button_press_emulator_press_timer.sv | 31 +++
 rtl/button_press_emulator.sv | 131 +++++++++++++
 4 files changed

// File: rtl/button_press_emulator_pkg.sv
// Shared types and the code-to-pattern mapping used by the emulator and its bench.
package lab2_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam int NUM_BUTTONS = 8;
  localparam int CODE_W      = $clog2(NUM_BUTTONS + 1);

  // Active-low level of line idx for a given code; code 0 yields a released line in both modes.
  function automatic logic pattern_bit(input int code, input logic one_hot, input int idx);
    if (one_hot) begin
      return (idx + 1) != code;
    end
    return idx >= code;
  endfunction

  function automatic logic [NUM_BUTTONS-1:0] code_to_pattern(input int code, input logic one_hot);
    logic [NUM_BUTTONS-1:0] pat;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      pat[i] = pattern_bit(code, one_hot, i);
    end
    return pat;
  endfunction

endpackage

// File: rtl/button_press_emulator_if.sv
// Code handshake between a stimulus source (master) and the emulator (slave).
interface button_press_emulator_if #(
  parameter int CODE_W = lab2_pkg::CODE_W
);
  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic              mode;
  logic              code_ready;

  modport master (output code_valid, output code, output mode, input code_ready);
  modport slave  (input code_valid, input code, input mode, output code_ready);
endinterface

// File: rtl/button_press_emulator_press_timer.sv
// Loadable down-counter shared by the press and release phases; holds at zero.
module press_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/button_press_emulator.sv
// Turns an encoded button index into a timed active-low press on a synthetic button bus.
module button_press_emulator
  import lab2_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PRESS_CYCLES = 1000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic                   clk,
  input  logic                   reset_n,
  button_press_emulator_if.slave bus,
  output logic [WIDTH-1:0]       buttons,
  output logic                   busy,
  output logic                   err,
  output logic [15:0]            press_count
);
  localparam int CODE_W  = $clog2(WIDTH + 1);
  localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_W-1:0] PRESS_LOAD = TIMER_W'(PRESS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [CODE_W-1:0]  MAX_CODE   = CODE_W'(WIDTH);

  if (PRESS_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
    $error("button_press_emulator: PRESS_CYCLES and GAP_CYCLES must both be >= 1");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   buttons_q, buttons_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [15:0]        count_q, count_d;
  logic [WIDTH-1:0]   pattern;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;
  logic               accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pattern
    assign pattern[gi] = pattern_bit(int'(bus.code), bus.mode, gi);
  end

  assign accept = bus.code_valid && ready_q;

  press_timer #(.W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    buttons_d   = buttons_q;
    ready_d     = ready_q;
    err_d       = 1'b0;
    count_d     = count_q;
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state_q)
      IDLE: begin
        ready_d   = 1'b1;
        buttons_d = '1;
        if (accept) begin
          if (bus.code == '0) begin
            state_d     = GAP;
            ready_d     = 1'b0;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end else if (bus.code <= MAX_CODE) begin
            state_d     = PRESS;
            buttons_d   = pattern;
            ready_d     = 1'b0;
            timer_load  = 1'b1;
            timer_value = PRESS_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRESS: begin
        if (timer_zero) begin
          state_d     = GAP;
          buttons_d   = '1;
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
          count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end
      end
      GAP: begin
        buttons_d = '1;
        if (timer_zero) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        buttons_d = '1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      buttons_q <= '1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      buttons_q <= buttons_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign bus.code_ready = ready_q;
  assign buttons        = buttons_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign press_count    = count_q;
endmodule
